// File: rtl/controle_cifra.sv
// controle_cifra: byte-stream front end for a 128-bit block cipher core.
//
// Collects up to 16 message bytes into a block, pads a short final block,
// starts the core with a one-cycle pulse, captures the result and hands it
// downstream with a valid/ready handshake.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   chave_in         128-bit key, key byte 0 in [127:120]
//   chave_carrega    key-load strobe (honoured only while idle)
//   byte_in          data byte
//   byte_valido      byte_in valid
//   byte_ultimo      byte_in is the final byte of the message
//   byte_pronto      controller accepts a byte this cycle
//   core_bloco       block to core, byte k at [8k+7:8k]
//   core_chave       key to core, key byte k at [8k+7:8k]
//   core_inicio      one-cycle start pulse to the core
//   core_fim         core result valid (may be tied high)
//   core_saida       core result, byte k at [8k+7:8k]
//   saida_bloco      ciphered block, byte k at [127-8k:120-8k]
//   saida_valido     saida_bloco valid
//   saida_pronto     downstream accepts the block
//   saida_ultimo     block carries the message's final byte
//   blocos_cont      number of blocks delivered downstream (wraps)
module controle_cifra #(
   parameter logic [7:0] PAD_BYTE  = 8'hFF,
   parameter int         LARG_CONT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [127:0]         chave_in,
   input  logic                 chave_carrega,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valido,
   input  logic                 byte_ultimo,
   output logic                 byte_pronto,
   output logic [127:0]         core_bloco,
   output logic [127:0]         core_chave,
   output logic                 core_inicio,
   input  logic                 core_fim,
   input  logic [127:0]         core_saida,
   output logic [127:0]         saida_bloco,
   output logic                 saida_valido,
   input  logic                 saida_pronto,
   output logic                 saida_ultimo,
   output logic [LARG_CONT-1:0] blocos_cont
);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      COLETA = 2'd1,
      CIFRA  = 2'd2,
      SAIDA  = 2'd3
   } estado_t;

   estado_t              estado_reg;
   logic                 chave_ok_reg;
   logic [127:0]         chave_reg;
   logic [127:0]         bloco_reg;
   logic [127:0]         saida_reg;
   logic [3:0]           cont_reg;
   logic                 ultimo_reg;
   logic                 inicio_reg;
   logic [LARG_CONT-1:0] blocos_reg;

   logic                 aceita;
   logic                 fecha;
   logic [127:0]         chave_rev;
   logic [127:0]         saida_rev;
   logic [127:0]         bloco_next;

   assign byte_pronto = ((estado_reg == OCIOSO) && chave_ok_reg) || (estado_reg == COLETA);
   assign aceita      = byte_valido && byte_pronto;
   // The block closes on the 16th byte or on the message's last byte.
   assign fecha       = byte_ultimo || (cont_reg == 4'd15);

   // Byte-lane plumbing. The key arrives big-endian and goes to the core
   // little-endian; the core result comes back little-endian and leaves
   // big-endian. Each block slot either takes the incoming byte, takes the
   // pad value (slots after a closing byte_ultimo), or holds.
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam logic [3:0] SLOT = 4'(gi);

      assign chave_rev[8*gi +: 8]       = chave_in[127-8*gi -: 8];
      assign saida_rev[127-8*gi -: 8]   = core_saida[8*gi +: 8];
      assign bloco_next[8*gi +: 8] =
         (aceita && (cont_reg == SLOT))                ? byte_in  :
         (aceita && byte_ultimo && (cont_reg < SLOT))  ? PAD_BYTE :
                                                         bloco_reg[8*gi +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_reg   <= OCIOSO;
         chave_ok_reg <= 1'b0;
         chave_reg    <= '0;
         bloco_reg    <= '0;
         saida_reg    <= '0;
         cont_reg     <= '0;
         ultimo_reg   <= 1'b0;
         inicio_reg   <= 1'b0;
         blocos_reg   <= '0;
      end else begin
         inicio_reg <= 1'b0;
         // bloco_next only differs from bloco_reg when a byte is accepted,
         // which cannot happen in CIFRA/SAIDA, so the core input holds.
         bloco_reg  <= bloco_next;

         case (estado_reg)
            OCIOSO, COLETA: begin
               if ((estado_reg == OCIOSO) && chave_carrega) begin
                  chave_ok_reg <= 1'b1;
                  chave_reg    <= chave_rev;
               end
               if (aceita) begin
                  if (fecha) begin
                     cont_reg   <= '0;
                     ultimo_reg <= byte_ultimo;
                     inicio_reg <= 1'b1;
                     estado_reg <= CIFRA;
                  end else begin
                     cont_reg   <= cont_reg + 4'd1;
                     estado_reg <= COLETA;
                  end
               end
            end

            CIFRA: begin
               if (core_fim) begin
                  saida_reg  <= saida_rev;
                  estado_reg <= SAIDA;
               end
            end

            SAIDA: begin
               if (saida_pronto) begin
                  blocos_reg <= blocos_reg + 1'b1;
                  estado_reg <= ultimo_reg ? OCIOSO : COLETA;
               end
            end

            default: estado_reg <= OCIOSO;
         endcase
      end
   end

   assign core_bloco   = bloco_reg;
   assign core_chave   = chave_reg;
   assign core_inicio  = inicio_reg;
   assign saida_bloco  = saida_reg;
   assign saida_valido = (estado_reg == SAIDA);
   assign saida_ultimo = (estado_reg == SAIDA) && ultimo_reg;
   assign blocos_cont  = blocos_reg;

endmodule

// File: tb/tb_controle_cifra.sv
// Directed testbench for controle_cifra. A second instance with a 2-bit
// block counter shares all inputs to exercise counter wrap.
module tb_controle_cifra;

   localparam logic [127:0] KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT       = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT       = 128'h3925841d02dc09fbdc118597196a0b32;
   // Same vectors in the core's little-endian byte order.
   localparam logic [127:0] KEY_CORE = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] PT_CORE  = 128'h340737e0a29831318d305a88a8f64332;
   localparam logic [127:0] CT_CORE  = 128'h320b6a19978511dcfb09dc021d842539;

   logic         clk;
   logic         rst;
   logic [127:0] chave_in;
   logic         chave_carrega;
   logic [7:0]   byte_in;
   logic         byte_valido;
   logic         byte_ultimo;
   logic         byte_pronto;
   logic [127:0] core_bloco;
   logic [127:0] core_chave;
   logic         core_inicio;
   logic         core_fim;
   logic [127:0] core_saida;
   logic [127:0] saida_bloco;
   logic         saida_valido;
   logic         saida_pronto;
   logic         saida_ultimo;
   logic [15:0]  blocos_cont;

   logic         byte_pronto_2;
   logic [127:0] core_bloco_2;
   logic [127:0] core_chave_2;
   logic         core_inicio_2;
   logic [127:0] saida_bloco_2;
   logic         saida_valido_2;
   logic         saida_ultimo_2;
   logic [1:0]   blocos_cont_2;

   int compared   = 0;
   int mismatched = 0;

   controle_cifra dut (
      .clk(clk), .rst(rst), .chave_in(chave_in), .chave_carrega(chave_carrega),
      .byte_in(byte_in), .byte_valido(byte_valido), .byte_ultimo(byte_ultimo),
      .byte_pronto(byte_pronto), .core_bloco(core_bloco), .core_chave(core_chave),
      .core_inicio(core_inicio), .core_fim(core_fim), .core_saida(core_saida),
      .saida_bloco(saida_bloco), .saida_valido(saida_valido),
      .saida_pronto(saida_pronto), .saida_ultimo(saida_ultimo),
      .blocos_cont(blocos_cont)
   );

   controle_cifra #(.LARG_CONT(2)) dut2 (
      .clk(clk), .rst(rst), .chave_in(chave_in), .chave_carrega(chave_carrega),
      .byte_in(byte_in), .byte_valido(byte_valido), .byte_ultimo(byte_ultimo),
      .byte_pronto(byte_pronto_2), .core_bloco(core_bloco_2), .core_chave(core_chave_2),
      .core_inicio(core_inicio_2), .core_fim(core_fim), .core_saida(core_saida),
      .saida_bloco(saida_bloco_2), .saida_valido(saida_valido_2),
      .saida_pronto(saida_pronto), .saida_ultimo(saida_ultimo_2),
      .blocos_cont(blocos_cont_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core stand-in: known-answer AES vector, otherwise block XOR key.
   always_comb begin
      core_saida = core_bloco ^ core_chave;
      if (core_bloco == PT_CORE && core_chave == KEY_CORE)
         core_saida = CT_CORE;
   end

   task automatic verifica(input string tag, input logic [127:0] obs, input logic [127:0] esp);
      compared++;
      if (obs !== esp) begin
         mismatched++;
         $display("FAIL %s: observed %h expected %h", tag, obs, esp);
      end
   endtask

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic envia_byte(input logic [7:0] b, input logic ult);
      int espera;
      espera      = 0;
      byte_in     = b;
      byte_ultimo = ult;
      byte_valido = 1'b1;
      while (!byte_pronto && espera < 50) begin
         ciclo();
         espera++;
      end
      if (!byte_pronto)
         verifica("byte_pronto_timeout", 128'(byte_pronto), 128'd1);
      ciclo();
      byte_valido = 1'b0;
      byte_ultimo = 1'b0;
   endtask

   task automatic envia_msg(input logic [127:0] msg, input int n, input logic ult);
      logic [7:0] b;
      for (int k = 0; k < n; k++) begin
         b = msg[127-8*k -: 8];
         envia_byte(b, ult && (k == n-1));
      end
   endtask

   task automatic espera_saida(input logic [127:0] esp, input logic ult, input string tag);
      int espera;
      espera = 0;
      while (!saida_valido && espera < 50) begin
         ciclo();
         espera++;
      end
      verifica({tag, "_valido"}, 128'(saida_valido), 128'd1);
      verifica({tag, "_bloco"},  saida_bloco, esp);
      verifica({tag, "_ultimo"}, 128'(saida_ultimo), 128'(ult));
      $display("saida %s: %h ultimo=%0b", tag, saida_bloco, saida_ultimo);
      saida_pronto = 1'b1;
      ciclo();
   endtask

   task automatic carrega_chave(input logic [127:0] k);
      chave_in      = k;
      chave_carrega = 1'b1;
      ciclo();
      chave_carrega = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] esp;
      int pulsos;

      rst = 1'b1; chave_in = '0; chave_carrega = 1'b0;
      byte_in = '0; byte_valido = 1'b0; byte_ultimo = 1'b0;
      core_fim = 1'b1; saida_pronto = 1'b1;
      ciclo(); ciclo();

      // Reset state
      verifica("rst_byte_pronto",  128'(byte_pronto),  128'd0);
      verifica("rst_core_inicio",  128'(core_inicio),  128'd0);
      verifica("rst_saida_valido", 128'(saida_valido), 128'd0);
      verifica("rst_saida_ultimo", 128'(saida_ultimo), 128'd0);
      verifica("rst_saida_bloco",  saida_bloco,        128'd0);
      verifica("rst_blocos_cont",  128'(blocos_cont),  128'd0);
      verifica("rst_core_bloco",   core_bloco,         128'd0);
      verifica("rst_core_chave",   core_chave,         128'd0);
      rst = 1'b0;

      // No key: bytes are refused and the core never starts
      byte_valido = 1'b1; byte_in = 8'h11;
      for (int i = 0; i < 5; i++) begin
         verifica("semchave_byte_pronto", 128'(byte_pronto), 128'd0);
         verifica("semchave_core_inicio", 128'(core_inicio), 128'd0);
         ciclo();
      end
      byte_valido = 1'b0;

      // Key load and known-answer block
      carrega_chave(KEY);
      verifica("chave_core",        core_chave,         KEY_CORE);
      verifica("chave_byte_pronto", 128'(byte_pronto), 128'd1);
      envia_msg(PT, 16, 1'b1);
      verifica("kat_inicio_t1",  128'(core_inicio),  128'd1);
      verifica("kat_core_bloco", core_bloco,         PT_CORE);
      verifica("kat_pronto_t1",  128'(byte_pronto),  128'd0);
      verifica("kat_valido_t1",  128'(saida_valido), 128'd0);
      ciclo();
      verifica("kat_valido_t2",  128'(saida_valido), 128'd1);
      verifica("kat_inicio_t2",  128'(core_inicio),  128'd0);
      espera_saida(CT, 1'b1, "kat");
      verifica("kat_blocos_cont", 128'(blocos_cont),  128'd1);
      verifica("kat_pos_pronto",  128'(byte_pronto),  128'd1);
      verifica("kat_pos_valido",  128'(saida_valido), 128'd0);

      // Three-byte message padded with 0xFF
      envia_msg(128'haabbcc00000000000000000000000000, 3, 1'b1);
      verifica("curta_core_bloco", core_bloco, 128'hffffffffffffffffffffffffffccbbaa);
      espera_saida(128'haabbccffffffffffffffffffffffffff ^ KEY, 1'b1, "curta");
      verifica("curta_blocos_cont", 128'(blocos_cont), 128'd2);

      // 32-byte message with downstream stalled after the first block
      saida_pronto = 1'b0;
      envia_msg(128'h000102030405060708090a0b0c0d0e0f, 16, 1'b0);
      verifica("longa_inicio", 128'(core_inicio), 128'd1);
      ciclo();
      byte_valido = 1'b1; byte_in = 8'h10;
      esp = 128'h000102030405060708090a0b0c0d0e0f ^ KEY;
      for (int i = 0; i < 5; i++) begin
         // A key strobe outside idle must be ignored.
         chave_carrega = (i == 0);
         chave_in      = ~KEY;
         verifica("stall_valido", 128'(saida_valido), 128'd1);
         verifica("stall_bloco",  saida_bloco,        esp);
         verifica("stall_pronto", 128'(byte_pronto),  128'd0);
         ciclo();
      end
      chave_carrega = 1'b0; chave_in = KEY; byte_valido = 1'b0;
      verifica("stall_chave", core_chave, KEY_CORE);
      espera_saida(esp, 1'b0, "bloco1");
      verifica("bloco1_pronto",  128'(byte_pronto),   128'd1);
      verifica("bloco1_cont",    128'(blocos_cont),   128'd3);
      verifica("bloco1_cont2",   128'(blocos_cont_2), 128'd3);
      envia_msg(128'h101112131415161718191a1b1c1d1e1f, 16, 1'b1);
      espera_saida(128'h101112131415161718191a1b1c1d1e1f ^ KEY, 1'b1, "bloco2");
      verifica("bloco2_cont",    128'(blocos_cont),   128'd4);
      verifica("wrap_cont2",     128'(blocos_cont_2), 128'd0);

      // Reset in the middle of a block
      envia_msg(128'h55565758595a5b000000000000000000, 7, 1'b0);
      rst = 1'b1;
      ciclo();
      verifica("mrst_byte_pronto",  128'(byte_pronto),  128'd0);
      verifica("mrst_core_inicio",  128'(core_inicio),  128'd0);
      verifica("mrst_saida_valido", 128'(saida_valido), 128'd0);
      verifica("mrst_saida_ultimo", 128'(saida_ultimo), 128'd0);
      verifica("mrst_saida_bloco",  saida_bloco,        128'd0);
      verifica("mrst_blocos_cont",  128'(blocos_cont),  128'd0);
      verifica("mrst_core_bloco",   core_bloco,         128'd0);
      verifica("mrst_core_chave",   core_chave,         128'd0);
      rst = 1'b0;
      ciclo();
      verifica("mrst_sem_chave", 128'(byte_pronto), 128'd0);
      carrega_chave(KEY);
      envia_msg(PT, 16, 1'b1);
      espera_saida(CT, 1'b1, "kat_pos_reset");
      verifica("kat_pos_reset_cont", 128'(blocos_cont), 128'd1);

      // Slow core: result valid 10 cycles into CIFRA
      core_fim = 1'b0;
      envia_msg(128'h01020000000000000000000000000000, 2, 1'b1);
      pulsos = int'(core_inicio);
      for (int i = 1; i < 10; i++) begin
         ciclo();
         pulsos += int'(core_inicio);
         verifica("lenta_bloco",  core_bloco,         128'hffffffffffffffffffffffffffff0201);
         verifica("lenta_chave",  core_chave,         KEY_CORE);
         verifica("lenta_valido", 128'(saida_valido), 128'd0);
      end
      core_fim = 1'b1;
      ciclo();
      verifica("lenta_pulsos", 128'(pulsos), 128'd1);
      espera_saida(128'h0102ffffffffffffffffffffffffffff ^ KEY, 1'b1, "lenta");
      verifica("lenta_cont", 128'(blocos_cont), 128'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/controle_cifra.md
CONTROLE_CIFRA -- requirements
Module: controle_cifra

Interface
REQ-001 Parameter PAD_BYTE, default 8'hFF: fill value for unreceived bytes of a partial final block.
REQ-002 Parameter LARG_CONT, default 16: width of the output block counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 chave_in  input  128  key; key byte 0 is in [127:120].
REQ-006 chave_carrega  input  1  key-load strobe, one cycle.
REQ-007 byte_in  input  8  data byte.
REQ-008 byte_valido  input  1  byte_in valid.
REQ-009 byte_ultimo  input  1  marks the final byte of the message; qualified by byte_valido.
REQ-010 byte_pronto  output  1  controller accepts a byte this cycle.
REQ-011 core_bloco  output  128  block to cipher core; byte k at [8k+7:8k].
REQ-012 core_chave  output  128  key to core; key byte k at [8k+7:8k].
REQ-013 core_inicio  output  1  one-cycle start pulse to core.
REQ-014 core_fim  input  1  core result valid; may be tied high for a combinational core.
REQ-015 core_saida  input  128  core result; byte k at [8k+7:8k].
REQ-016 saida_bloco  output  128  ciphered block; byte k at [127-8k:120-8k].
REQ-017 saida_valido  output  1  saida_bloco valid.
REQ-018 saida_pronto  input  1  downstream accepts the block.
REQ-019 saida_ultimo  output  1  block carries the message's final byte.
REQ-020 blocos_cont  output  LARG_CONT  count of blocks delivered downstream.

Function
REQ-021 States: OCIOSO, COLETA, CIFRA, SAIDA.
REQ-022 Key-loaded flag: set by chave_carrega in OCIOSO; key register latches chave_in; chave_carrega in any other state is ignored.
REQ-023 byte_pronto is 1 only in OCIOSO with key loaded, or in COLETA; it is 0 otherwise.
REQ-024 A byte is accepted when byte_valido and byte_pronto are both 1; the k-th accepted byte (k=0..15) is stored in block slot k.
REQ-025 OCIOSO -> COLETA on the first accepted byte, unless the transition to CIFRA (REQ-026) applies.
REQ-026 Transition -> CIFRA on the cycle the 16th byte is accepted, or on any accepted byte with byte_ultimo=1.
REQ-027 When a block closes with n<16 bytes, slots n..15 are set to PAD_BYTE.
REQ-028 When exactly 16 bytes end with byte_ultimo, no extra pad block is generated.
REQ-029 Byte counter resets to 0 when each block closes.
REQ-030 core_inicio is 1 for exactly the first cycle in CIFRA.
REQ-031 core_bloco and core_chave are held stable throughout CIFRA.
REQ-032 In CIFRA, core_fim=1 captures core_saida into the output register, byte-reversed per REQ-016, and the next state is SAIDA.
REQ-033 core_fim is ignored outside CIFRA.
REQ-034 Latency: last byte of a block accepted at cycle t; core_inicio=1 at t+1; with core_fim tied high, saida_valido=1 at t+2.
REQ-035 In SAIDA, saida_valido=1 and saida_bloco/saida_ultimo are held until saida_pronto=1.
REQ-036 On the SAIDA handshake: blocos_cont increments, wrapping modulo 2^LARG_CONT; next state is OCIOSO if saida_ultimo=1, else COLETA.
REQ-037 saida_ultimo is 1 when the block was closed by byte_ultimo.
REQ-038 No new byte is accepted in CIFRA or SAIDA.

Reset
REQ-039 With rst=1 at a clock edge, the following hold from any state, including mid-block:
- state = OCIOSO
- key-loaded flag cleared; key register = 0
- byte counter = 0; block register = 0
- byte_pronto = 0, core_inicio = 0, saida_valido = 0, saida_ultimo = 0
- saida_bloco = 0, blocos_cont = 0, core_bloco = 0, core_chave = 0
REQ-040 rst has priority over all other inputs, and any partial block is discarded.

Verification
REQ-041 No key loaded, byte_valido=1 -> byte_pronto stays 0 and no core_inicio.
REQ-042 Full block with core_fim tied high:
- stimulus: key 2b7e1516..., 16 bytes 3243f6a8..., last with byte_ultimo; core = reference AES
- response: saida_bloco = 3925841d02dc09fbdc118597196a0b32; saida_ultimo=1; blocos_cont=1; t+2 latency.
REQ-043 3-byte message with byte_ultimo on byte 2 -> core_bloco bytes 3..15 = 8'hFF; bytes 0..2 equal the inputs.
REQ-044 32-byte message, saida_pronto held low 5 cycles after the first block -> block 1 held stable; byte_pronto=0 for those cycles; second block follows; blocos_cont=2.
REQ-045 rst asserted after 7 bytes -> all outputs 0 next cycle; after key reload, a fresh 16-byte block produces the correct cipher.
REQ-046 blocos_cont preset near wrap with LARG_CONT=2 -> 4 blocks delivered gives blocos_cont=0; multi-cycle core with core_fim at 10 cycles -> inputs stable and a single core_inicio.
